// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the interrupt sequencer.
// Contents:
//   seq_state_t       - interrupt entry / RETI unwind sequencer states
//   STACK_FRAME_BYTES - bytes pushed per interrupt entry (PCH, PCL, flags)
//   DEFAULT_IE_BIT    - bit of the pushed flag byte that carries saved ie
//   FLAG_*            - bit positions of the CPU flag register
package cpu_pkg;

   typedef enum logic [3:0] {
      IDLE     = 4'd0,
      PUSH_PCH = 4'd1,
      PUSH_PCL = 4'd2,
      PUSH_FLG = 4'd3,
      VECTOR   = 4'd4,
      POP_FLG  = 4'd5,
      POP_PCL  = 4'd6,
      POP_PCH  = 4'd7,
      RESTORE  = 4'd8
   } seq_state_t;

   localparam int STACK_FRAME_BYTES = 3;
   localparam int DEFAULT_IE_BIT    = 7;

   localparam int FLAG_C = 0;
   localparam int FLAG_Z = 1;
   localparam int FLAG_N = 2;
   localparam int FLAG_V = 3;

endpackage

// File: rtl/int_sequencer.sv
// CPU-side interrupt sequencer. Accepts a PIC request at an instruction
// boundary, pushes PC and flags to the stack, redirects the PC to the
// vector and pulses intAck; also unwinds RETI and owns the global ie bit.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   interrupt, intVect, intAck - PIC request level, handler address, taken pulse
//   inst_done, reti, sei, cli  - CPU boundary and decoded control instructions
//   pc, flags                  - current CPU PC and flags (captured on entry)
//   stall                      - freezes fetch/execute while sequencing
//   stk_req/we/wdata/rdata/ack - byte-wide stack access handshake
//   pc_load, pc_next           - one-cycle PC load
//   flags_load, flags_out      - one-cycle flag restore
//   ie                         - global interrupt enable
module int_sequencer
   import cpu_pkg::*;
#(
   parameter int FLAG_W = 4,
   parameter int IE_BIT = DEFAULT_IE_BIT
)(
   input  logic              clk,
   input  logic              reset,
   input  logic              interrupt,
   input  logic [15:0]       intVect,
   output logic              intAck,
   input  logic              inst_done,
   input  logic              reti,
   input  logic              sei,
   input  logic              cli,
   input  logic [15:0]       pc,
   input  logic [FLAG_W-1:0] flags,
   output logic              stall,
   output logic              stk_req,
   output logic              stk_we,
   output logic [7:0]        stk_wdata,
   input  logic [7:0]        stk_rdata,
   input  logic              stk_ack,
   output logic              pc_load,
   output logic [15:0]       pc_next,
   output logic              flags_load,
   output logic [FLAG_W-1:0] flags_out,
   output logic              ie
);

   seq_state_t state, state_nx;

   // Captured on acceptance
   logic [15:0]       pc_q;
   logic [15:0]       vect_q;
   logic [FLAG_W-1:0] flags_q;
   logic              ie_saved;
   // Collected during RETI unwind
   logic [FLAG_W-1:0] rest_flags_q;
   logic              rest_ie_q;
   logic [7:0]        rest_lo_q;
   logic [7:0]        rest_hi_q;

   logic [7:0]        flag_byte;
   logic              accept;

   // Padding bits of the popped flag byte carry no state
   logic              pad_unused;
   assign pad_unused = ^stk_rdata;

   // ie is the registered value, so an SEI at this boundary cannot enable
   // acceptance until the following boundary.
   assign accept = inst_done && !reti && interrupt && ie;

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nx;
   end

   // ---------------- next state ----------------
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE: begin
            if (inst_done && reti) state_nx = POP_FLG;
            else if (accept)       state_nx = PUSH_PCH;
         end
         PUSH_PCH: if (stk_ack) state_nx = PUSH_PCL;
         PUSH_PCL: if (stk_ack) state_nx = PUSH_FLG;
         PUSH_FLG: if (stk_ack) state_nx = VECTOR;
         VECTOR:                state_nx = IDLE;
         POP_FLG:  if (stk_ack) state_nx = POP_PCL;
         POP_PCL:  if (stk_ack) state_nx = POP_PCH;
         POP_PCH:  if (stk_ack) state_nx = RESTORE;
         RESTORE:               state_nx = IDLE;
         default:               state_nx = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      flag_byte                = '0;
      flag_byte[FLAG_W-1:0]    = flags_q;
      flag_byte[IE_BIT]        = ie_saved;
   end

   always_comb begin
      intAck     = 1'b0;
      stk_req    = 1'b0;
      stk_we     = 1'b0;
      stk_wdata  = '0;
      pc_load    = 1'b0;
      pc_next    = '0;
      flags_load = 1'b0;
      flags_out  = '0;
      stall      = (state != IDLE);
      unique case (state)
         PUSH_PCH: begin
            stk_req   = 1'b1;
            stk_we    = 1'b1;
            stk_wdata = pc_q[15:8];
         end
         PUSH_PCL: begin
            stk_req   = 1'b1;
            stk_we    = 1'b1;
            stk_wdata = pc_q[7:0];
         end
         PUSH_FLG: begin
            stk_req   = 1'b1;
            stk_we    = 1'b1;
            stk_wdata = flag_byte;
         end
         VECTOR: begin
            pc_load = 1'b1;
            pc_next = vect_q;
            intAck  = 1'b1;
         end
         POP_FLG, POP_PCL, POP_PCH: begin
            stk_req = 1'b1;
         end
         RESTORE: begin
            pc_load    = 1'b1;
            pc_next    = {rest_hi_q, rest_lo_q};
            flags_load = 1'b1;
            flags_out  = rest_flags_q;
         end
         default: ;
      endcase
   end

   // ---------------- ie and capture registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ie           <= 1'b0;
         pc_q         <= '0;
         vect_q       <= '0;
         flags_q      <= '0;
         ie_saved     <= 1'b0;
         rest_flags_q <= '0;
         rest_ie_q    <= 1'b0;
         rest_lo_q    <= '0;
         rest_hi_q    <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (inst_done && !reti) begin
                  if (accept) begin
                     pc_q     <= pc;
                     vect_q   <= intVect;
                     flags_q  <= flags;
                     ie_saved <= ie;
                     ie       <= 1'b0;
                  end else if (cli) begin
                     ie <= 1'b0;
                  end else if (sei) begin
                     ie <= 1'b1;
                  end
               end
            end
            POP_FLG: if (stk_ack) begin
               rest_flags_q <= stk_rdata[FLAG_W-1:0];
               rest_ie_q    <= stk_rdata[IE_BIT];
            end
            POP_PCL: if (stk_ack) rest_lo_q <= stk_rdata;
            POP_PCH: if (stk_ack) rest_hi_q <= stk_rdata;
            RESTORE: ie <= rest_ie_q;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_int_sequencer.sv
// Self-checking bench for int_sequencer: directed scenarios followed by a
// randomized phase, all checked against a frame-level model of interrupt
// entry / return (stack of {pc, flags, ie} frames plus the ie bit).
module tb_int_sequencer;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        interrupt = 1'b0;
   logic [15:0] intVect = '0;
   logic        intAck;
   logic        inst_done = 1'b0;
   logic        reti = 1'b0;
   logic        sei = 1'b0;
   logic        cli = 1'b0;
   logic [15:0] pc = '0;
   logic [3:0]  flags = '0;
   logic        stall;
   logic        stk_req;
   logic        stk_we;
   logic [7:0]  stk_wdata;
   logic [7:0]  stk_rdata = '0;
   logic        stk_ack = 1'b0;
   logic        pc_load;
   logic [15:0] pc_next;
   logic        flags_load;
   logic [3:0]  flags_out;
   logic        ie;

   int_sequencer #(.FLAG_W(4), .IE_BIT(7)) dut (
      .clk(clk), .reset(reset), .interrupt(interrupt), .intVect(intVect),
      .intAck(intAck), .inst_done(inst_done), .reti(reti), .sei(sei),
      .cli(cli), .pc(pc), .flags(flags), .stall(stall), .stk_req(stk_req),
      .stk_we(stk_we), .stk_wdata(stk_wdata), .stk_rdata(stk_rdata),
      .stk_ack(stk_ack), .pc_load(pc_load), .pc_next(pc_next),
      .flags_load(flags_load), .flags_out(flags_out), .ie(ie)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- stack unit model ----------------
   int unsigned wait_n  = 0;   // wait cycles before each ack
   logic        spur_en = 1'b0; // random acks while no request is pending
   logic [7:0]  bstack[$];
   logic [7:0]  push_log[$];
   int unsigned wcnt = 0;

   always @(negedge clk) begin
      if (reset) begin
         stk_ack = 1'b0;
         wcnt    = 0;
         bstack.delete();
      end else if (stk_req) begin
         if (wcnt >= wait_n) begin
            stk_ack = 1'b1;
            wcnt    = 0;
            if (stk_we) begin
               bstack.push_back(stk_wdata);
               push_log.push_back(stk_wdata);
            end else begin
               stk_rdata = (bstack.size() > 0) ? bstack.pop_back() : 8'h00;
            end
         end else begin
            stk_ack = 1'b0;
            wcnt++;
         end
      end else begin
         wcnt      = 0;
         stk_ack   = spur_en && ($urandom_range(0, 3) == 0);
         stk_rdata = 8'($urandom);
      end
   end

   // ---------------- reference model ----------------
   typedef struct {
      logic [15:0] pc;
      logic [3:0]  fl;
      logic        ie;
   } frame_t;

   frame_t mstack[$];
   logic   m_ie = 1'b0;

   // One instruction boundary with the given controls, then follow any
   // sequence it starts until the CPU is released. Called at negedge+1.
   task automatic boundary(input logic r, input logic s, input logic c, input logic irq,
                           input logic [15:0] p, input logic [3:0] f, input logic [15:0] v);
      logic        exp_entry;
      frame_t      fr;
      int unsigned log0, stalls, acks, loads, floads, exp_stalls;
      logic [15:0] ld_pc;
      logic [3:0]  ld_fl;
      logic        fl_same, done;
      logic        prev_req, prev_we, prev_ack;
      logic [7:0]  prev_wd;
      logic [31:0] got_b;
      logic [7:0]  exp_b[3];

      exp_entry = !r && irq && m_ie;
      log0 = push_log.size();
      inst_done = 1'b1; reti = r; sei = s; cli = c; interrupt = irq;
      pc = p; flags = f; intVect = v;
      check("idle_stall", stall, 0);
      @(negedge clk); #1;
      inst_done = 1'b0; reti = 1'b0; sei = 1'b0; cli = 1'b0;
      if ($urandom_range(0, 1) == 1) interrupt = 1'b0;
      intVect = 16'($urandom); pc = 16'($urandom); flags = 4'($urandom);

      if (!r && !exp_entry) begin
         if (c)      m_ie = 1'b0;
         else if (s) m_ie = 1'b1;
         check("noseq_stall", stall, 0);
         check("noseq_req", stk_req, 0);
         check("noseq_ack", intAck, 0);
         check("noseq_ie", ie, m_ie);
         interrupt = 1'b0;
         return;
      end

      stalls = 0; acks = 0; loads = 0; floads = 0; done = 1'b0;
      ld_pc = '0; ld_fl = '0; fl_same = 1'b0;
      prev_req = 1'b0; prev_we = 1'b0; prev_ack = 1'b1; prev_wd = '0;
      for (int i = 0; i < 200; i++) begin
         if (!stall) begin
            done = 1'b1;
            break;
         end
         stalls++;
         if (intAck) acks++;
         if (pc_load) begin
            loads++;
            ld_pc = pc_next;
         end
         if (flags_load) begin
            floads++;
            ld_fl   = flags_out;
            fl_same = pc_load;
         end
         if (prev_req && prev_we && !prev_ack && stk_req)
            check("wdata_hold", stk_wdata, prev_wd);
         prev_req = stk_req; prev_we = stk_we; prev_ack = stk_ack; prev_wd = stk_wdata;
         // Controls arriving mid-sequence must be ignored
         inst_done = 1'($urandom); reti = 1'($urandom);
         sei = 1'($urandom); cli = 1'($urandom);
         @(negedge clk); #1;
      end
      inst_done = 1'b0; reti = 1'b0; sei = 1'b0; cli = 1'b0; interrupt = 1'b0;

      exp_stalls = 3 * (wait_n + 1) + 1;
      check("seq_done", done, 1);
      check("stall_cycles", stalls, exp_stalls);
      check("pc_load_cnt", loads, 1);

      if (exp_entry) begin
         exp_b[0] = p[15:8];
         exp_b[1] = p[7:0];
         exp_b[2] = 8'(f) | (8'(m_ie) << 7);
         check("push_cnt", push_log.size() - log0, 3);
         for (int k = 0; k < 3; k++) begin
            got_b = (log0 + k < push_log.size()) ? 32'(push_log[log0 + k]) : 32'hDEAD;
            check("push_byte", got_b, 32'(exp_b[k]));
         end
         check("vector_pc", ld_pc, v);
         check("intack_cnt", acks, 1);
         check("entry_fload", floads, 0);
         check("entry_ie", ie, 0);
         mstack.push_back('{pc: p, fl: f, ie: m_ie});
         m_ie = 1'b0;
      end else begin
         fr = mstack.pop_back();
         check("ret_push_cnt", push_log.size() - log0, 0);
         check("ret_pc", ld_pc, fr.pc);
         check("ret_fload", floads, 1);
         check("ret_flags", ld_fl, fr.fl);
         check("ret_same_cyc", fl_same, 1);
         check("ret_intack", acks, 0);
         check("ret_ie", ie, fr.ie);
         m_ie = fr.ie;
      end
   endtask

   task automatic check_outputs_zero(input string pfx);
      check({pfx, "_intAck"}, intAck, 0);
      check({pfx, "_stall"}, stall, 0);
      check({pfx, "_stk_req"}, stk_req, 0);
      check({pfx, "_stk_we"}, stk_we, 0);
      check({pfx, "_stk_wdata"}, stk_wdata, 0);
      check({pfx, "_pc_load"}, pc_load, 0);
      check({pfx, "_pc_next"}, pc_next, 0);
      check({pfx, "_flags_load"}, flags_load, 0);
      check({pfx, "_flags_out"}, flags_out, 0);
      check({pfx, "_ie"}, ie, 0);
   endtask

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      logic        found;
      int unsigned acks_seen;

      repeat (3) @(negedge clk);
      #1;
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk); #1;

      // Basic entry and return
      boundary(0, 1, 0, 0, 16'h0000, 4'h0, 16'h0000);
      boundary(0, 0, 0, 1, 16'h1234, 4'b1010, 16'h0200);
      boundary(1, 0, 0, 0, 16'h0000, 4'h0, 16'h0000);

      // Masking, then SEI at the same boundary as a request
      boundary(0, 0, 1, 0, 16'h0000, 4'h0, 16'h0000);
      for (int i = 0; i < 20; i++)
         boundary(0, 0, 0, 1, 16'($urandom), 4'($urandom), 16'($urandom));
      boundary(0, 1, 0, 1, 16'h4000, 4'h5, 16'h0300);
      boundary(0, 0, 0, 1, 16'h4002, 4'h6, 16'h0300);

      // Stack wait states, nesting, RETI beating a pending request
      wait_n = 3;
      boundary(0, 1, 0, 0, 16'h0000, 4'h0, 16'h0000);
      boundary(0, 0, 0, 1, 16'h0310, 4'h9, 16'h0400);
      boundary(1, 0, 0, 1, 16'h0000, 4'h0, 16'h0500);
      boundary(0, 0, 0, 1, 16'h0306, 4'h3, 16'h0500);
      boundary(1, 0, 0, 0, 16'h0000, 4'h0, 16'h0000);
      boundary(1, 0, 0, 0, 16'h0000, 4'h0, 16'h0000);

      // Async reset while PCL is being pushed
      boundary(0, 1, 0, 0, 16'h0000, 4'h0, 16'h0000);
      inst_done = 1'b1; interrupt = 1'b1; pc = 16'hABCD; flags = 4'h7; intVect = 16'h0600;
      @(negedge clk); #1;
      inst_done = 1'b0;
      found = 1'b0;
      acks_seen = 0;
      for (int i = 0; i < 20; i++) begin
         if (intAck) acks_seen++;
         if (stk_req && stk_we && stk_wdata == 8'hCD) begin
            found = 1'b1;
            break;
         end
         @(negedge clk); #1;
      end
      check("rst_mid_reached_pcl", found, 1);
      #1 reset = 1'b1;
      #1;
      check_outputs_zero("rst_mid");
      repeat (2) begin
         @(negedge clk); #1;
         if (intAck) acks_seen++;
      end
      check("rst_mid_no_ack", acks_seen, 0);
      interrupt = 1'b0;
      reset = 1'b0;
      m_ie = 1'b0;
      mstack.delete();
      wait_n = 0;
      @(negedge clk); #1;
      check_outputs_zero("post_rst");
      boundary(0, 0, 0, 1, 16'h1111, 4'h1, 16'h0700);
      boundary(0, 1, 0, 0, 16'h0000, 4'h0, 16'h0000);
      boundary(0, 0, 0, 1, 16'h2222, 4'h2, 16'h0800);
      boundary(1, 0, 0, 0, 16'h0000, 4'h0, 16'h0000);

      // Randomized phase
      spur_en = 1'b1;
      for (int i = 0; i < 150; i++) begin
         logic rr, ss, cc, ii;
         wait_n = $urandom_range(0, 3);
         rr = ($urandom_range(0, 3) == 0) && (mstack.size() > 0);
         ss = ($urandom_range(0, 3) == 0);
         cc = ($urandom_range(0, 6) == 0);
         ii = ($urandom_range(0, 2) != 0);
         boundary(rr, ss, cc, ii, 16'($urandom), 4'($urandom), 16'($urandom));
         if ($urandom_range(0, 2) == 0) begin
            @(negedge clk); #1;
         end
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/int_sequencer.md
Name: int_sequencer

Overview:
CPU-side end of the interrupt request/acknowledge interface; the PIC is the other end. It takes `interrupt`/`intVect` from the PIC and accepts the request at an instruction boundary. It pushes PC and flags to the stack, redirects the PC to the vector, and pulses `intAck` so the PIC retires the pending bit. It also runs the RETI unwind sequence and owns the global interrupt-enable bit (`ie`).

Parameters:
FLAG_W, 4, width of CPU flag register (must be <= 7)
IE_BIT, 7, bit of the pushed flag byte that carries saved `ie`

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
interrupt  in  1  request from PIC, level, held until intAck
intVect  in  16  handler address from PIC, valid while interrupt=1
intAck  out  1  one-cycle pulse to PIC: vector taken
inst_done  in  1  CPU at instruction boundary this cycle
reti  in  1  decoded RETI completing this cycle (qualified by inst_done)
sei  in  1  set ie (qualified by inst_done)
cli  in  1  clear ie (qualified by inst_done)
pc  in  16  address of next instruction
flags  in  FLAG_W  current CPU flags
stall  out  1  freeze fetch/execute while sequencing
stk_req  out  1  stack access request
stk_we  out  1  1=push, 0=pop
stk_wdata  out  8  push data
stk_rdata  in  8  pop data, valid with stk_ack
stk_ack  in  1  stack access complete; the stack unit adjusts SP
pc_load  out  1  one-cycle: load pc_next into PC
pc_next  out  16  new PC value
flags_load  out  1  one-cycle: load flags_out into flags
flags_out  out  FLAG_W  restored flags
ie  out  1  global interrupt enable

Behaviour:
- Reset (async) gives the following outputs and state:
  - state=IDLE, ie=0
  - intAck=0, stall=0, stk_req=0, stk_we=0, stk_wdata=0
  - pc_load=0, pc_next=0, flags_load=0, flags_out=0
  - All capture registers cleared.
  - Reset mid-sequence abandons partial pushes/pops; no ack is issued.
- FSM states: IDLE, PUSH_PCH, PUSH_PCL, PUSH_FLG, VECTOR, POP_FLG, POP_PCL, POP_PCH, RESTORE.
- IDLE, at inst_done=1, priority order:
  - reti → POP_FLG.
  - else interrupt&ie → capture pc, flags, intVect and `ie`; clear ie; → PUSH_PCH.
  - else sei/cli update ie next cycle; cli wins if both.
- Acceptance uses the registered ie, so an instruction executing SEI cannot be interrupted at its own boundary; the earliest acceptance is the next boundary.
- stall=1 in every state except IDLE. The transition cycle out of IDLE keeps stall=0 because the CPU is at a boundary.
- Push states: stk_req=1, stk_we=1; advance only on stk_ack.
  - PUSH_PCH pushes pc_q[15:8].
  - PUSH_PCL pushes pc_q[7:0].
  - PUSH_FLG pushes {ie_saved at IE_BIT, zero padding, flags_q[FLAG_W-1:0]}.
- VECTOR (1 cycle):
  - pc_load=1, pc_next=vect_q, intAck=1, then → IDLE.
  - Total entry latency is 3 pushes plus 1 cycle, assuming no stack wait states.
- Pop states: stk_req=1, stk_we=0; capture stk_rdata on stk_ack.
  - Order: POP_FLG, POP_PCL, POP_PCH (reverse of push).
- RESTORE (1 cycle):
  - pc_load=1, pc_next={hi,lo}.
  - flags_load=1, flags_out=saved flags.
  - ie ← saved IE bit, then → IDLE.
- Deasserting `interrupt` after acceptance does not abort the entry. The vector captured at acceptance is used and intAck is still pulsed, which the PIC tolerates.
- Nested interrupts: handler SEI re-enables ie, and a new request is accepted at the next boundary. The stack grows; there is no depth limit here.
- Tail-chaining: an interrupt pending at RETI is accepted at the first boundary after RESTORE, provided the restored ie=1.
- sei/cli/reti/interrupt are ignored outside IDLE.
- stk_ack outside the push/pop states is ignored.

Decomposition:
- Shared package `cpu_pkg`:
  - state enum constants (4-bit encoding)
  - STACK_FRAME_BYTES=3
  - IE_BIT default
  - flag bit positions used by the CPU
- No sub-module: the push/pop sequencer is one FSM plus capture registers.

Test Plan:
- Entry: ie=1, pc=0x1234, flags=4'b1010, intVect=0x0200, interrupt+inst_done, stk_ack every cycle → pushes 0x12, 0x34, 0x8A; then pc_load with pc_next=0x0200 and intAck pulsed exactly 1 cycle; ie=0 afterwards; stall high for 4 cycles.
- Return: reti+inst_done, stk_rdata 0x8A, 0x34, 0x12 → pc_next=0x1234, flags_out=4'b1010, ie=1, with pc_load and flags_load pulsed together.
- Masking: ie=0, interrupt held for 20 boundaries → no stk_req, no intAck. Then sei at one boundary and an interrupt at the same boundary → not accepted; accepted at the next boundary.
- Stack wait states: stk_ack delayed 3 cycles per access → state holds, stk_wdata stable, stall stays high; sequence completes correctly.
- Priority: reti and interrupt at the same boundary with ie_saved=1 → pop completes first, then the interrupt is accepted at the next inst_done with a fresh 3-byte push.
- Reset mid-push: async reset asserted during PUSH_PCL → all outputs 0 immediately, ie=0, no intAck; after release, IDLE responds normally.
